// File: rtl/udp_vlg_pkg.sv
// Shared types and constants for the UDP TX path and its packet buffer.
package udp_vlg_pkg;

  localparam int unsigned UDP_HDR_LEN = 8;

  // One byte of a framed stream.
  typedef struct packed {
    logic [7:0] dat;
    logic       val;
    logic       sof;
    logic       eof;
    logic       err;
  } stream_t;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] length;
    logic [15:0] chsum;
  } udp_hdr_t;

  typedef struct packed {
    logic [31:0] dst_ip;
  } ipv4_hdr_t;

  typedef struct packed {
    ipv4_hdr_t ipv4_hdr;
    udp_hdr_t  udp_hdr;
  } udp_meta_t;

  // Packet buffer FSM encoding.
  typedef logic [2:0] udp_tx_buf_fsm_t;

  localparam udp_tx_buf_fsm_t ST_IDLE      = 3'd0;
  localparam udp_tx_buf_fsm_t ST_FILL      = 3'd1;
  localparam udp_tx_buf_fsm_t ST_PEND      = 3'd2;
  localparam udp_tx_buf_fsm_t ST_WAIT_REQ  = 3'd3;
  localparam udp_tx_buf_fsm_t ST_SEND      = 3'd4;
  localparam udp_tx_buf_fsm_t ST_WAIT_DONE = 3'd5;

endpackage

// File: rtl/udp_vlg_tx_pkt_buf_if.sv
// Handshake between a UDP payload source (out_tx) and the UDP TX stage (in_tx).
interface udp_vlg_tx_pkt_buf_if;
  import udp_vlg_pkg::*;

  stream_t   strm;
  udp_meta_t meta;
  logic      rdy;
  logic      req;
  logic      ack;
  logic      done;

  modport out_tx (output strm, output meta, output rdy,
                  input req, input ack, input done);

  modport in_tx  (input strm, input meta, input rdy,
                  output req, output ack, output done);
endinterface

// File: rtl/udp_vlg_tx_buf_ram.sv
// Simple dual-port byte RAM: one write port, registered read that returns 0 when idle.
module udp_vlg_tx_buf_ram #(
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_dat_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_dat_o
);
  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_dat_q;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  // Read register doubles as the stream data register, so it is zero when not reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else if (rd_en_i) begin
      rd_dat_q <= mem_q[rd_addr_i];
    end else begin
      rd_dat_q <= '0;
    end
  end

  assign rd_dat_o = rd_dat_q;
endmodule

// File: rtl/udp_vlg_tx_pkt_buf.sv
// Single-packet buffer in front of the UDP TX stage: collects a datagram, then replays it on request.
module udp_vlg_tx_pkt_buf
  import udp_vlg_pkg::*;
#(
  parameter int unsigned BUF_AW    = 11,
  parameter int unsigned MTU_BYTES = 1472,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_dat,
  input  logic                 in_val,
  input  logic                 in_eof,
  input  logic [15:0]          in_src_port,
  input  logic [15:0]          in_dst_port,
  input  logic [31:0]          in_dst_ip,
  output logic                 in_rdy,
  output logic                 in_drop,
  udp_vlg_tx_pkt_buf_if.out_tx udp
);
  localparam int unsigned CNT_W = BUF_AW + 1;
  localparam int unsigned TMR_W = 16;

  if (MTU_BYTES > (32'd1 << BUF_AW)) begin : g_chk_depth
    $error("MTU_BYTES does not fit in the packet buffer");
  end
  if (MTU_BYTES + UDP_HDR_LEN >= 32'd65536) begin : g_chk_len
    $error("MTU_BYTES plus UDP header does not fit the 16-bit length field");
  end

  udp_tx_buf_fsm_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             dscd_q, dscd_d;
  logic [15:0]      src_q, src_d;
  logic [15:0]      dst_q, dst_d;
  logic [31:0]      ip_q, ip_d;
  udp_meta_t        meta_q, meta_d;
  logic             rdy_q, rdy_d;
  logic             in_rdy_q, in_rdy_d;
  logic             in_drop_q, in_drop_d;
  logic             val_q, val_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;

  logic              acc_c;
  logic              tmo_c;
  logic              wr_en_c;
  logic [BUF_AW-1:0] wr_addr_c;
  logic              rd_en_c;
  logic [BUF_AW-1:0] rd_addr_c;
  logic [7:0]        rd_dat;
  stream_t           strm_c;

  assign acc_c = in_val & in_rdy_q;
  assign tmo_c = (timer_q == TMR_W'(TIMEOUT));

  udp_vlg_tx_buf_ram #(
    .AW (BUF_AW)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (wr_addr_c),
    .wr_dat_i  (in_dat),
    .rd_en_i   (rd_en_c),
    .rd_addr_i (rd_addr_c),
    .rd_dat_o  (rd_dat)
  );

  // Next-state, buffer access and output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    dscd_d    = dscd_q;
    src_d     = src_q;
    dst_d     = dst_q;
    ip_d      = ip_q;
    meta_d    = meta_q;
    rdy_d     = rdy_q;
    in_drop_d = 1'b0;
    val_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    rd_en_c   = 1'b0;
    rd_addr_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (acc_c) begin
          wr_en_c = 1'b1;
          src_d   = in_src_port;
          dst_d   = in_dst_port;
          ip_d    = in_dst_ip;
          cnt_d   = CNT_W'(1);
          state_d = in_eof ? ST_PEND : ST_FILL;
        end
      end

      ST_FILL: begin
        if (dscd_q) begin
          // Overflowed packet: swallow bytes until its end marker.
          if (in_val && in_eof) begin
            state_d = ST_IDLE;
          end
        end else if (acc_c) begin
          if (cnt_q == CNT_W'(MTU_BYTES)) begin
            in_drop_d = 1'b1;
            if (in_eof) begin
              state_d = ST_IDLE;
            end else begin
              dscd_d = 1'b1;
            end
          end else begin
            wr_en_c   = 1'b1;
            wr_addr_c = cnt_q[BUF_AW-1:0];
            cnt_d     = cnt_q + CNT_W'(1);
            if (in_eof) begin
              state_d = ST_PEND;
            end
          end
        end
      end

      ST_PEND: begin
        meta_d                  = '0;
        meta_d.udp_hdr.src_port = src_q;
        meta_d.udp_hdr.dst_port = dst_q;
        meta_d.udp_hdr.length   = 16'(cnt_q) + 16'(UDP_HDR_LEN);
        meta_d.ipv4_hdr.dst_ip  = ip_q;
        rdy_d                   = 1'b1;
        state_d                 = ST_WAIT_REQ;
      end

      ST_WAIT_REQ: begin
        if (udp.ack) begin
          rdy_d = 1'b0;
        end
        if (udp.req) begin
          // Address 0 goes out now so the first byte lands on strm next cycle.
          rdy_d     = 1'b0;
          rd_en_c   = 1'b1;
          rd_addr_c = '0;
          val_d     = 1'b1;
          sof_d     = 1'b1;
          eof_d     = (cnt_q == CNT_W'(1));
          rd_ptr_d  = CNT_W'(1);
          state_d   = ST_SEND;
        end else if (tmo_c) begin
          in_drop_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (rd_ptr_q == cnt_q) begin
          state_d = ST_WAIT_DONE;
        end else begin
          rd_en_c   = 1'b1;
          rd_addr_c = rd_ptr_q[BUF_AW-1:0];
          val_d     = 1'b1;
          eof_d     = (rd_ptr_q == cnt_q - CNT_W'(1));
          rd_ptr_d  = rd_ptr_q + CNT_W'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (udp.done || tmo_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Returning to IDLE releases the packet.
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      dscd_d   = 1'b0;
      meta_d   = '0;
      rdy_d    = 1'b0;
    end

    timer_d = '0;
    if (state_d == state_q) begin
      timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_W'(1);
    end

    in_rdy_d = (state_d == ST_IDLE) || (state_d == ST_FILL && !dscd_d);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      timer_q   <= '0;
      dscd_q    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      ip_q      <= '0;
      meta_q    <= '0;
      rdy_q     <= 1'b0;
      in_rdy_q  <= 1'b1;
      in_drop_q <= 1'b0;
      val_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      timer_q   <= timer_d;
      dscd_q    <= dscd_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      ip_q      <= ip_d;
      meta_q    <= meta_d;
      rdy_q     <= rdy_d;
      in_rdy_q  <= in_rdy_d;
      in_drop_q <= in_drop_d;
      val_q     <= val_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
    end
  end

  // Stream beat: data straight from the RAM read register, framing from local flags.
  always_comb begin
    strm_c     = '0;
    strm_c.dat = rd_dat;
    strm_c.val = val_q;
    strm_c.sof = sof_q;
    strm_c.eof = eof_q;
  end

  assign in_rdy   = in_rdy_q;
  assign in_drop  = in_drop_q;
  assign udp.rdy  = rdy_q;
  assign udp.meta = meta_q;
  assign udp.strm = strm_c;
endmodule

// File: doc/udp_vlg_tx_pkt_buf.md
Name: udp_vlg_tx_pkt_buf

Overview:
- Packet buffer that sits directly upstream of the UDP TX stage and drives it through the udp interface `out_tx` modport.
- Accepts one user datagram byte-by-byte, stores it, and computes its length.
- Then presents rdy and meta (ports, IP, length) and replays the payload when the UDP TX stage requests it.
- Holds exactly one packet; the user side is back-pressured while a packet is pending or in flight.

Parameters:
- BUF_AW, 11, buffer address width; depth 2^BUF_AW bytes (2048).
- MTU_BYTES, 1472, maximum UDP payload; a longer packet is dropped.
- TIMEOUT, 65535, cycles allowed in each wait state before the packet is abandoned.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_dat  input  8  user payload byte.
- in_val  input  1  in_dat valid; a byte is accepted when in_val & in_rdy.
- in_eof  input  1  marks the last payload byte; qualified by in_val.
- in_src_port  input  16  UDP source port; sampled with the first accepted byte.
- in_dst_port  input  16  UDP destination port; sampled with the first byte.
- in_dst_ip  input  32  destination IPv4 address; sampled with the first byte.
- in_rdy  output  1  buffer can accept bytes.
- in_drop  output  1  one-cycle pulse: current packet discarded (overflow or timeout).
- udp  interface  `out_tx` modport  strm/meta/rdy out; req/ack/done in.

Behaviour:
- The interface decision is fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - in_rdy=1, in_drop=0.
  - udp.rdy=0 and all udp.strm fields 0.
  - udp.meta cleared.
  - Write and read pointers and byte count all 0.
- Reset applies in any state and abandons a packet mid-fill or mid-send with no eof emitted.
- FSM states: IDLE, FILL, PEND, WAIT_REQ, SEND, WAIT_DONE.
- IDLE: in_rdy=1.
  - First accepted byte is written to address 0; ports and IP are latched; count=1.
  - If in_eof is set with that byte, go to PEND; otherwise go to FILL.
- FILL: each accepted byte is written at count, then count increments.
  - Accepted byte with in_eof -> PEND.
  - If count would exceed MTU_BYTES -> pulse in_drop, set in_rdy=0, and discard bytes until in_eof is seen, then go to IDLE.
  - Overflow packets never reach udp.
  - Gaps in in_val are legal.
- PEND (one cycle): load meta.
  - udp_hdr.src_port and dst_port from the latched ports.
  - udp_hdr.length = count + 8, 16-bit.
  - udp_hdr.chsum = 0 (checksum disabled).
  - ipv4_hdr.dst_ip from the latched IP.
  - Assert udp.rdy, then go to WAIT_REQ.
  - in_rdy=0 from PEND through WAIT_DONE.
- WAIT_REQ: udp.rdy and meta are held stable.
  - udp.ack drops udp.rdy on the next cycle; meta stays stable until return to IDLE.
  - udp.req -> SEND. If req arrives with rdy still high, rdy also drops.
  - Timer expiry -> pulse in_drop, go to IDLE.
- SEND: buffer RAM has 1-cycle registered read.
  - Address 0 is presented in the req cycle, so the first byte appears on strm the cycle after req.
  - One byte per cycle thereafter, strm.val=1 continuously.
  - strm.sof=1 on the first byte only; strm.eof=1 on byte count-1 only.
  - A single-byte packet has sof=eof=1 in the same cycle.
  - strm.err=0 always.
  - Latency from req to eof = count cycles.
  - After eof -> WAIT_DONE.
- WAIT_DONE: strm is all zeros.
  - udp.done -> IDLE, in_rdy=1 on the next cycle.
  - Timer expiry -> IDLE without an in_drop pulse, since data was already sent.
- Timer: 16-bit counter, cleared on every state entry, saturates. Expiry condition is timer == TIMEOUT.
- Simultaneous events:
  - req and ack in the same cycle behave as ack followed by req.
  - done arriving during SEND is ignored.
  - req outside WAIT_REQ is ignored.
- Width rules: count is BUF_AW+1 bits. Elaboration asserts MTU_BYTES <= 2^BUF_AW and MTU_BYTES + 8 < 65536.

Decomposition:
- Add the state enum type `udp_tx_buf_fsm_t` and the constant `UDP_HDR_LEN` = 8 to `udp_vlg_pkg`.
- stream_t and udp_meta_t are reused unchanged.
- One sub-module, `udp_vlg_tx_buf_ram`: simple dual-port RAM, 2^BUF_AW x 8, one write port, registered read.

Test Plan:
- 4-byte packet 0xDE AD BE EF, src 1000, dst 2000, IP 192.168.1.10, req 3 cycles after rdy:
  - meta.udp_hdr.length=12, chsum=0.
  - Bytes appear in order one cycle after req; sof on 0xDE, eof on 0xEF.
  - done returns in_rdy=1.
- 1-byte packet (in_eof on the first byte): length=9; single strm cycle with sof=eof=1.
- 1473-byte packet (MTU+1):
  - in_drop pulses at byte 1473; udp.rdy never asserts.
  - in_rdy=1 after the in_eof byte.
  - A following 10-byte packet sends with length=18.
- No req for TIMEOUT (set to 100) cycles: in_drop pulses at cycle 100; rdy=0 and back to IDLE. The next packet is processed normally.
- Randomised gaps in in_val over a 1472-byte packet: length=1480; payload matches byte-for-byte; in_rdy=0 from PEND until done.
- rst asserted mid-SEND at byte 50 of 100: next cycle all outputs are at reset values and no eof is emitted. The next packet is sent intact.
